vicii_sprite_bank: RTL and testbench

VICII_SPRITE_BANK -- requirements
Module: vicii_sprite_bank

---
 rtl/vicii_pkg.sv | 11 +
 rtl/vicii_sprite_chan.sv | 174 +++++++++++++++++
 rtl/vicii_sprite_bank.sv | 136 +++++++++++++
 tb/tb_vicii_sprite_bank.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vicii_pkg.sv
// Shared constants and types for the VIC-II sprite bank.
package vicii_pkg;

    localparam int unsigned SLOT_LEN    = 16;
    localparam logic [6:0]  SPR_PTR_OFS = 7'h7F;
    localparam logic [5:0]  MC_END      = 6'd63;
    localparam int unsigned SPR_W       = 24;

    typedef logic [3:0] color_t;

endpackage

// File: rtl/vicii_sprite_chan.sv
// One sprite channel: 16-cycle pointer/data fetch slot, line counters and the display shifter.
module vicii_sprite_chan
    import vicii_pkg::*;
#(
    parameter int unsigned IDX  = 0,
    parameter int unsigned BASE = 352
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  xc_i,
    input  logic [8:0]  yc_i,
    input  logic [7:0]  di_i,
    input  logic [3:0]  vm1_i,
    input  logic [8:0]  x_i,
    input  logic [7:0]  y_i,
    input  logic        en_i,
    input  logic        xe_i,
    input  logic        ye_i,
    input  logic        mcm_i,
    input  color_t      col_i,
    input  color_t      smc0_i,
    input  color_t      smc1_i,
    output logic [13:0] ao_o,
    output logic        ba_o,
    output logic        opaque_o,
    output color_t      color_o
);

    localparam logic [9:0] BaseW = 10'(BASE);

    logic [9:0]       rel;
    logic             in_win, fetch, start, disp, last;
    logic             active_q, active_d, tog_q, tog_d;
    logic             armed_q, armed_d, shifting_q, shifting_d;
    logic [5:0]       mc_q, mc_d, mcbase_q, mcbase_d;
    logic [5:0]       k_q, k_d, k_cur;
    logic [7:0]       mp_q, mp_d;
    logic [SPR_W-1:0] dat_q, dat_d, sh_q, sh_d, cur;
    logic [1:0]       dv_q, dv_d, dv_cur, lim;

    assign rel    = {1'b0, xc_i} - BaseW;
    assign in_win = ({1'b0, xc_i} >= BaseW) && (rel <= 10'(SLOT_LEN));
    // A channel that has counted past the last line keeps its slot but fetches nothing.
    assign fetch  = active_q && (mcbase_q != MC_END);
    assign ba_o   = in_win && (rel != 10'd0) && fetch;

    assign start  = armed_q && (xc_i == x_i);
    assign disp   = start || shifting_q;
    assign cur    = start ? dat_q : sh_q;
    assign dv_cur = start ? 2'd0 : dv_q;
    assign k_cur  = start ? 6'd0 : k_q;
    assign lim    = mcm_i ? (xe_i ? 2'd3 : 2'd1) : (xe_i ? 2'd1 : 2'd0);
    assign last   = k_cur == (xe_i ? 6'(2 * SPR_W - 1) : 6'(SPR_W - 1));

    always_comb begin
        ao_o = 14'h0;
        if (in_win) begin
            case (rel[4:0])
                5'd0:                ao_o = {vm1_i, SPR_PTR_OFS, 3'(IDX)};
                5'd4, 5'd8, 5'd12:   if (fetch) ao_o = {mp_q, mc_q};
                default:             ao_o = 14'h0;
            endcase
        end
    end

    always_comb begin
        opaque_o = 1'b0;
        color_o  = col_i;
        if (disp) begin
            if (mcm_i) begin
                case (cur[SPR_W-1 -: 2])
                    2'b01:   begin opaque_o = 1'b1; color_o = smc0_i; end
                    2'b10:   begin opaque_o = 1'b1; color_o = col_i;  end
                    2'b11:   begin opaque_o = 1'b1; color_o = smc1_i; end
                    default: opaque_o = 1'b0;
                endcase
            end else begin
                opaque_o = cur[SPR_W-1];
            end
        end
    end

    always_comb begin
        active_d   = active_q;
        tog_d      = tog_q;
        armed_d    = armed_q;
        shifting_d = shifting_q;
        mc_d       = mc_q;
        mcbase_d   = mcbase_q;
        mp_d       = mp_q;
        dat_d      = dat_q;
        sh_d       = sh_q;
        dv_d       = dv_q;
        k_d        = k_q;

        // Loaded data is consumed by exactly one display pass.
        if (disp) begin
            if (start) armed_d = 1'b0;
            if (dv_cur == lim) begin
                dv_d = 2'd0;
                sh_d = mcm_i ? (cur << 2) : (cur << 1);
            end else begin
                dv_d = dv_cur + 2'd1;
                sh_d = cur;
            end
            shifting_d = !last;
            k_d        = last ? 6'd0 : k_cur + 6'd1;
        end

        if (in_win) begin
            case (rel[4:0])
                5'd0: begin
                    if (!active_q && en_i && (yc_i == {1'b0, y_i})) begin
                        active_d = 1'b1;
                        mcbase_d = 6'd0;
                        mc_d     = 6'd0;
                        tog_d    = 1'b0;
                    end else begin
                        mc_d = mcbase_q;
                    end
                end
                5'd2: begin
                    if (fetch) mp_d = di_i;
                    else if (active_q) active_d = 1'b0;
                end
                5'd4, 5'd8, 5'd12: if (fetch) mc_d = mc_q + 6'd1;
                5'd6:  if (fetch) dat_d[23:16] = di_i;
                5'd10: if (fetch) dat_d[15:8] = di_i;
                5'd14: begin
                    if (fetch) begin
                        dat_d[7:0] = di_i;
                        armed_d    = 1'b1;
                    end
                end
                5'd16: begin
                    if (fetch) begin
                        if (!ye_i || tog_q) mcbase_d = mc_q;
                        if (ye_i) tog_d = !tog_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= 1'b0;
            tog_q      <= 1'b0;
            armed_q    <= 1'b0;
            shifting_q <= 1'b0;
            mc_q       <= MC_END;
            mcbase_q   <= MC_END;
            mp_q       <= 8'h0;
            dat_q      <= '0;
            sh_q       <= '0;
            dv_q       <= 2'd0;
            k_q        <= 6'd0;
        end else begin
            active_q   <= active_d;
            tog_q      <= tog_d;
            armed_q    <= armed_d;
            shifting_q <= shifting_d;
            mc_q       <= mc_d;
            mcbase_q   <= mcbase_d;
            mp_q       <= mp_d;
            dat_q      <= dat_d;
            sh_q       <= sh_d;
            dv_q       <= dv_d;
            k_q        <= k_d;
        end
    end

endmodule

// File: rtl/vicii_sprite_bank.sv
// Sprite bank: NSPR channels, bus address/request merge, priority mux and collision registers.
module vicii_sprite_bank
    import vicii_pkg::*;
#(
    parameter int unsigned NSPR        = 8,
    parameter int unsigned FETCH_START = 352
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          di,
    input  logic [3:0]          vm1,
    input  logic [8:0]          xc,
    input  logic [8:0]          yc,
    input  logic [9*NSPR-1:0]   spr_x,
    input  logic [8*NSPR-1:0]   spr_y,
    input  logic [NSPR-1:0]     spr_en,
    input  logic [NSPR-1:0]     spr_xe,
    input  logic [NSPR-1:0]     spr_ye,
    input  logic [NSPR-1:0]     spr_mcm,
    input  logic [4*NSPR-1:0]   spr_col,
    input  logic [3:0]          smc0,
    input  logic [3:0]          smc1,
    input  logic                bg_fg,
    input  logic                mm_rd,
    input  logic                md_rd,
    output logic [13:0]         ao,
    output logic                ba,
    output logic                pixel_enable,
    output logic [3:0]          pixel,
    output logic [2:0]          pixel_idx,
    output logic [NSPR-1:0]     mm,
    output logic [NSPR-1:0]     md,
    output logic                irq_mm,
    output logic                irq_md
);

    logic [13:0]     chan_ao [NSPR];
    color_t          chan_col [NSPR];
    logic [NSPR-1:0] chan_ba, op;
    logic [13:0]     ao_or;
    logic            multi;
    color_t          win_col;
    logic [2:0]      win_idx;

    logic            pix_en_q;
    color_t          pix_q;
    logic [2:0]      idx_q;
    logic [NSPR-1:0] mm_q, mm_d, md_q, md_d;
    logic            irq_mm_q, irq_mm_d, irq_md_q, irq_md_d;

    for (genvar g = 0; g < NSPR; g++) begin : g_chan
        vicii_sprite_chan #(
            .IDX  (g),
            .BASE (FETCH_START + SLOT_LEN * g)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .xc_i     (xc),
            .yc_i     (yc),
            .di_i     (di),
            .vm1_i    (vm1),
            .x_i      (spr_x[9*g +: 9]),
            .y_i      (spr_y[8*g +: 8]),
            .en_i     (spr_en[g]),
            .xe_i     (spr_xe[g]),
            .ye_i     (spr_ye[g]),
            .mcm_i    (spr_mcm[g]),
            .col_i    (spr_col[4*g +: 4]),
            .smc0_i   (smc0),
            .smc1_i   (smc1),
            .ao_o     (chan_ao[g]),
            .ba_o     (chan_ba[g]),
            .opaque_o (op[g]),
            .color_o  (chan_col[g])
        );
    end

    // Slots never overlap on a driven address, so an OR merge is enough.
    always_comb begin
        ao_or = 14'h0;
        for (int i = 0; i < int'(NSPR); i++) ao_or |= chan_ao[i];
    end

    assign ao = reset ? 14'h0 : ao_or;
    assign ba = !reset && (|chan_ba);

    always_comb begin
        win_col = 4'h0;
        win_idx = 3'd0;
        for (int i = int'(NSPR) - 1; i >= 0; i--) begin
            if (op[i]) begin
                win_col = chan_col[i];
                win_idx = 3'(i);
            end
        end
    end

    assign multi = |(op & (op - NSPR'(1)));

    // A collision in the same cycle as a read-clear strobe still sets its bit.
    always_comb begin
        mm_d     = (mm_rd ? '0 : mm_q) | (multi ? op : '0);
        md_d     = (md_rd ? '0 : md_q) | (bg_fg ? op : '0);
        irq_mm_d = (mm_q == '0) && (mm_d != '0);
        irq_md_d = (md_q == '0) && (md_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en_q <= 1'b0;
            pix_q    <= 4'h0;
            idx_q    <= 3'd0;
            mm_q     <= '0;
            md_q     <= '0;
            irq_mm_q <= 1'b0;
            irq_md_q <= 1'b0;
        end else begin
            pix_en_q <= |op;
            pix_q    <= win_col;
            idx_q    <= win_idx;
            mm_q     <= mm_d;
            md_q     <= md_d;
            irq_mm_q <= irq_mm_d;
            irq_md_q <= irq_md_d;
        end
    end

    assign pixel_enable = pix_en_q;
    assign pixel        = pix_q;
    assign pixel_idx    = idx_q;
    assign mm           = mm_q;
    assign md           = md_q;
    assign irq_mm       = irq_mm_q;
    assign irq_md       = irq_md_q;

endmodule

// File: tb/tb_vicii_sprite_bank.sv
// Directed bench for vicii_sprite_bank: timed expectations and a pixel scoreboard, checked by a monitor.
module tb_vicii_sprite_bank;

    localparam int NSPR        = 8;
    localparam int FETCH_START = 352;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          di;
    logic [3:0]          vm1;
    logic [8:0]          xc, yc;
    logic [9*NSPR-1:0]   spr_x;
    logic [8*NSPR-1:0]   spr_y;
    logic [NSPR-1:0]     spr_en, spr_xe, spr_ye, spr_mcm;
    logic [4*NSPR-1:0]   spr_col;
    logic [3:0]          smc0, smc1;
    logic                bg_fg, mm_rd, md_rd;
    logic [13:0]         ao;
    logic                ba, pixel_enable;
    logic [3:0]          pixel;
    logic [2:0]          pixel_idx;
    logic [NSPR-1:0]     mm, md;
    logic                irq_mm, irq_md;

    typedef enum int {KAo, KBa, KPe, KIdx, KMm, KMd, KIrqMm, KIrqMd, KPqEmpty} kind_e;
    typedef struct { int cyc; kind_e kind; int exp; string name; } exp_t;
    typedef struct { int col; int idx; } pix_t;

    exp_t       tq[$];
    pix_t       pq[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         test_id = 0;
    logic [7:0]  ptr_tbl [NSPR];
    logic [23:0] dat_tbl [NSPR];

    always #5 clk = ~clk;

    vicii_sprite_bank #(
        .NSPR        (NSPR),
        .FETCH_START (FETCH_START)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .di           (di),
        .vm1          (vm1),
        .xc           (xc),
        .yc           (yc),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_en       (spr_en),
        .spr_xe       (spr_xe),
        .spr_ye       (spr_ye),
        .spr_mcm      (spr_mcm),
        .spr_col      (spr_col),
        .smc0         (smc0),
        .smc1         (smc1),
        .bg_fg        (bg_fg),
        .mm_rd        (mm_rd),
        .md_rd        (md_rd),
        .ao           (ao),
        .ba           (ba),
        .pixel_enable (pixel_enable),
        .pixel        (pixel),
        .pixel_idx    (pixel_idx),
        .mm           (mm),
        .md           (md),
        .irq_mm       (irq_mm),
        .irq_md       (irq_md)
    );

    // Monitor: timed expectations plus the pixel stream, sampled mid-cycle.
    always @(negedge clk) begin
        int   got;
        exp_t e;
        pix_t p;
        while (tq.size() > 0 && tq[0].cyc <= cyc) begin
            e = tq.pop_front();
            case (e.kind)
                KAo:      got = int'(ao);
                KBa:      got = int'(ba);
                KPe:      got = int'(pixel_enable);
                KIdx:     got = int'(pixel_idx);
                KMm:      got = int'(mm);
                KMd:      got = int'(md);
                KIrqMm:   got = int'(irq_mm);
                KIrqMd:   got = int'(irq_md);
                default:  got = pq.size();
            endcase
            n_checks++;
            if (e.cyc == cyc && got == e.exp) n_pass++;
            else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, due %0d)",
                          e.name, got, e.exp, cyc, e.cyc);
        end
        if (pixel_enable === 1'b1) begin
            n_checks++;
            if (pq.size() == 0) begin
                $display("FAIL unexpected_pixel: got color %0d idx %0d, expected none (cycle %0d)",
                         pixel, pixel_idx, cyc);
            end else begin
                p = pq.pop_front();
                if (int'(pixel) == p.col && int'(pixel_idx) == p.idx) n_pass++;
                else $display("FAIL pixel: got color %0d idx %0d, expected color %0d idx %0d (cycle %0d)",
                              pixel, pixel_idx, p.col, p.idx, cyc);
            end
        end
    end

    task automatic expect_now(input kind_e k, input int v, input string nm);
        exp_t e;
        e.cyc = cyc; e.kind = k; e.exp = v; e.name = nm;
        tq.push_back(e);
    endtask

    task automatic push_pix(input int col, input int idx, input int count);
        pix_t p;
        p.col = col; p.idx = idx;
        for (int i = 0; i < count; i++) pq.push_back(p);
    endtask

    // Memory model: pointer at slot+2, data bytes at slot+6/+10/+14.
    function automatic logic [7:0] mem_byte(input int x);
        logic [7:0] r;
        r = 8'h00;
        for (int n = 0; n < NSPR; n++) begin
            int rel;
            rel = x - (FETCH_START + 16 * n);
            if (rel == 2)  r = ptr_tbl[n];
            if (rel == 6)  r = dat_tbl[n][23:16];
            if (rel == 10) r = dat_tbl[n][15:8];
            if (rel == 14) r = dat_tbl[n][7:0];
        end
        return r;
    endfunction

    task automatic hook(input int x, input int y);
        case (test_id)
            1: begin
                if (y == 50 && x >= 352 && x <= 370)
                    expect_now(KBa, (x >= 353 && x <= 368) ? 1 : 0, "ba_slot");
                if (y == 50 && x == 352) expect_now(KAo, 'h3F8, "ao_ptr");
                if (y == 50 && x == 354) expect_now(KAo, 0, "ao_gap");
                if (y == 50 && x == 356) expect_now(KAo, 'h800, "ao_data0");
                if (y == 50 && x == 360) expect_now(KAo, 'h801, "ao_data1");
                if (y == 50 && x == 364) expect_now(KAo, 'h802, "ao_data2");
                if (y == 51 && x == 356) expect_now(KAo, 'h803, "ao_line2");
                if (y == 51 && x == 100) expect_now(KPe, 0, "pe_before");
                if (y == 51 && x == 101) expect_now(KPe, 1, "pe_first");
                if (y == 51 && x == 108) expect_now(KPe, 1, "pe_last");
                if (y == 51 && x == 109) expect_now(KPe, 0, "pe_after");
                if (x == 361) expect_now(KBa, (y <= 70) ? 1 : 0, "ba_line");
                if (y == 72 && x == 352) expect_now(KAo, 'h3F8, "ao_ptr_idle");
                if (y == 72 && x == 353) expect_now(KBa, 0, "ba_idle");
            end
            2: begin
                if (y == 51 && x == 116) expect_now(KPe, 1, "xe_pe_last");
                if (y == 51 && x == 117) expect_now(KPe, 0, "xe_pe_after");
            end
            3: begin
                if (y == 80 && x == 385) expect_now(KBa, 1, "ba_ch2");
                if (y == 80 && x == 401) expect_now(KBa, 0, "ba_ch3_idle");
                if (y == 80 && x == 433) expect_now(KBa, 1, "ba_ch5");
                if (y == 81 && x == 200) expect_now(KMm, 0, "mm_before");
                if (y == 81 && x == 201) begin
                    expect_now(KMm, 'h24, "mm_set");
                    expect_now(KIrqMm, 1, "irq_mm_pulse");
                    expect_now(KIdx, 2, "idx_winner");
                end
                if (y == 81 && x == 202) expect_now(KIrqMm, 0, "irq_mm_end");
                if (y == 81 && x == 203) bg_fg = 1'b1;
                if (y == 81 && x == 204) begin
                    expect_now(KMd, 'h24, "md_set");
                    expect_now(KIrqMd, 1, "irq_md_pulse");
                end
                if (y == 81 && x == 205) begin
                    expect_now(KIrqMd, 0, "irq_md_end");
                    mm_rd = 1'b1;
                    md_rd = 1'b1;
                end
                if (y == 81 && x == 206) begin
                    expect_now(KMm, 'h24, "mm_rd_collide");
                    expect_now(KMd, 0, "md_rd_clear");
                    expect_now(KIrqMm, 0, "irq_mm_quiet");
                end
                if (y == 81 && x == 300) begin
                    expect_now(KMm, 'h24, "mm_hold");
                    mm_rd = 1'b1;
                end
                if (y == 81 && x == 301) expect_now(KMm, 0, "mm_rd_clear");
            end
            4: begin
                if (y == 51 && x == 106) expect_now(KPe, 1, "mc_pe_last");
                if (y == 51 && x == 107) expect_now(KPe, 0, "mc_pe_after");
            end
            5: begin
                if (x == 356 && y == 50) expect_now(KAo, 'h800, "ye_ao_l0");
                if (x == 356 && y == 51) expect_now(KAo, 'h800, "ye_ao_l1");
                if (x == 356 && y == 52) expect_now(KAo, 'h803, "ye_ao_l2");
                if (x == 356 && y == 53) expect_now(KAo, 'h803, "ye_ao_l3");
                if (x == 361) expect_now(KBa, (y <= 91) ? 1 : 0, "ye_ba_line");
            end
            6: begin
                if (y == 50 && x == 359) expect_now(KBa, 1, "ba_pre_reset");
                if (y == 50 && x == 360) reset = 1'b1;
                if (y == 50 && x == 361) begin
                    reset = 1'b0;
                    expect_now(KBa, 0, "ba_after_reset");
                    expect_now(KAo, 0, "ao_after_reset");
                    expect_now(KPe, 0, "pe_after_reset");
                    expect_now(KMm, 0, "mm_after_reset");
                end
                if (y == 50 && x == 365) expect_now(KBa, 0, "ba_stays_low");
                if (y == 51 && x == 101) expect_now(KPe, 0, "no_partial_display");
            end
            default: ;
        endcase
    endtask

    task automatic tick(input int x, input int y);
        @(posedge clk);
        #1;
        xc    = 9'(x);
        yc    = 9'(y);
        di    = mem_byte(x);
        bg_fg = 1'b0;
        mm_rd = 1'b0;
        md_rd = 1'b0;
        cyc++;
        hook(x, y);
    endtask

    task automatic run_lines(input int first, input int last);
        for (int y = first; y <= last; y++)
            for (int x = 0; x < 512; x++) tick(x, y);
    endtask

    task automatic do_reset();
        test_id = 0;
        reset   = 1'b1;
        tick(0, 0);
        reset   = 1'b0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_xe = '0; spr_ye = '0; spr_mcm = '0;
        spr_col = '0;
        for (int n = 0; n < NSPR; n++) begin
            ptr_tbl[n] = 8'h20 + 8'(n);
            dat_tbl[n] = 24'h0;
        end
    endtask

    task automatic end_test();
        test_id = 0;
        tick(0, 0);
        expect_now(KPqEmpty, 0, "pixel_count");
    endtask

    task automatic cfg_chan(input int n, input int x, input int y, input int col,
                            input logic [23:0] dat);
        spr_en[n]          = 1'b1;
        spr_x[9*n +: 9]    = 9'(x);
        spr_y[8*n +: 8]    = 8'(y);
        spr_col[4*n +: 4]  = 4'(col);
        dat_tbl[n]         = dat;
    endtask

    initial begin
        reset = 1'b1; di = 8'h0; vm1 = 4'h0; xc = 9'd0; yc = 9'd0;
        smc0 = 4'd5; smc1 = 4'd9; bg_fg = 1'b0; mm_rd = 1'b0; md_rd = 1'b0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_xe = '0; spr_ye = '0; spr_mcm = '0;
        spr_col = '0;
        for (int n = 0; n < NSPR; n++) begin
            ptr_tbl[n] = 8'h20 + 8'(n);
            dat_tbl[n] = 24'h0;
        end

        tick(0, 0);
        expect_now(KAo, 0, "rst_ao");
        expect_now(KBa, 0, "rst_ba");
        expect_now(KPe, 0, "rst_pe");
        expect_now(KIdx, 0, "rst_idx");
        expect_now(KMm, 0, "rst_mm");
        expect_now(KMd, 0, "rst_md");
        expect_now(KIrqMm, 0, "rst_irq_mm");
        expect_now(KIrqMd, 0, "rst_irq_md");

        // Hires fetch/display over 21 lines.
        do_reset();
        cfg_chan(0, 100, 50, 1, 24'hFF0000);
        push_pix(1, 0, 21 * 8);
        test_id = 1;
        run_lines(50, 72);
        end_test();

        // X expand doubles pixel width.
        do_reset();
        cfg_chan(0, 100, 50, 1, 24'hFF0000);
        spr_xe[0] = 1'b1;
        push_pix(1, 0, 16);
        test_id = 2;
        run_lines(50, 51);
        end_test();

        // Two overlapping sprites: priority and collisions.
        do_reset();
        cfg_chan(2, 200, 80, 3, 24'hFF0000);
        cfg_chan(5, 200, 80, 7, 24'hFF0000);
        push_pix(3, 2, 8);
        test_id = 3;
        run_lines(80, 81);
        end_test();

        // Multicolor pairs 01,10,11,00.
        do_reset();
        cfg_chan(0, 100, 50, 2, 24'h6C0000);
        spr_mcm[0] = 1'b1;
        push_pix(5, 0, 2);
        push_pix(2, 0, 2);
        push_pix(9, 0, 2);
        test_id = 4;
        run_lines(50, 51);
        end_test();

        // Y expand: every data line fetched and shown twice.
        do_reset();
        cfg_chan(0, 100, 50, 1, 24'hFF0000);
        spr_ye[0] = 1'b1;
        push_pix(1, 0, 42 * 8);
        test_id = 5;
        run_lines(50, 93);
        end_test();

        // Reset in the middle of a fetch slot.
        do_reset();
        cfg_chan(0, 100, 50, 1, 24'hFF0000);
        spr_ye[0] = 1'b1;
        test_id = 6;
        run_lines(50, 51);
        end_test();

        tick(0, 0);
        tick(0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
